// File: rtl/mil_spi_channel_dispatch.sv
`default_nettype none
// ============================================================================
//  Module   : mil_spi_channel_dispatch
//  Purpose  : Multi-channel MIL/SPI command dispatcher. Decodes the LinkSpi
//             packet address and command into a per-channel configuration:
//             ring-buffer open/commit/rollback pulses, push gates, the pop
//             mux select, the reply size, per-channel error counters and a
//             stretched active-low device-reset request.
//  Ports    : clk, nRst (async, active low)
//             inAddr/inCmdCode/inSize, inPacketStart/End/Err  - LinkSpi side
//             memUsedMS/memUsedSM   - per-channel fill levels (16 bit each)
//             outAddr/outCmdCode/outDataSize/outEnable - reply to LinkSpi
//             smOpen/smCommit/smRollback - one-hot SPI->MIL buffer pulses
//             enablePushFromSpi/enablePushToMil - per-channel push gates
//             popSel/popSrcStatus/statusEnable/statusWord0..2 - pop mux
//             nResetRequest - active-low device reset request
//  Config   : MIL_SPI_PKT_TIMEOUT_EN enables the ACTIVE-state watchdog
//             (PKT_TIMEOUT cycles); without it PKT_TIMEOUT is ignored.
//  Revision : 1.0 - initial multi-channel release
// ============================================================================

package ServiceProtocol;
    typedef enum logic [3:0] {
        TCC_UNKNOWN      = 4'h0,
        TCC_RESET        = 4'h1,
        TCC_SEND_DATA    = 4'h2,
        TCC_RECEIVE_STS  = 4'h3,
        TCC_RECEIVE_DATA = 4'h4
    } TCommandCode;
endpackage

module mil_spi_channel_dispatch
    import ServiceProtocol::*;
#(
    parameter int         NUM_CH      = 4,
    parameter logic [7:0] BASE_ADDR   = 8'hAB,
    parameter logic [7:0] BCAST_ADDR  = 8'hFF,
    parameter int         RST_HOLD    = 16,
    parameter int         PKT_TIMEOUT = 4096,
    localparam int        CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk,
    input  logic                 nRst,
    input  logic [7:0]           inAddr,
    input  TCommandCode          inCmdCode,
    input  logic [15:0]          inSize,
    input  logic                 inPacketStart,
    input  logic                 inPacketEnd,
    input  logic                 inPacketErr,
    input  logic [NUM_CH*16-1:0] memUsedMS,
    input  logic [NUM_CH*16-1:0] memUsedSM,
    output logic [7:0]           outAddr,
    output TCommandCode          outCmdCode,
    output logic [15:0]          outDataSize,
    output logic                 outEnable,
    output logic [NUM_CH-1:0]    smOpen,
    output logic [NUM_CH-1:0]    smCommit,
    output logic [NUM_CH-1:0]    smRollback,
    output logic [NUM_CH-1:0]    enablePushFromSpi,
    output logic [NUM_CH-1:0]    enablePushToMil,
    output logic [CH_W-1:0]      popSel,
    output logic                 popSrcStatus,
    output logic                 statusEnable,
    output logic [15:0]          statusWord0,
    output logic [15:0]          statusWord1,
    output logic [15:0]          statusWord2,
    output logic                 nResetRequest
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    localparam int         RC_W       = $clog2(RST_HOLD + 1);
    localparam logic [8:0] FIRST_ADDR = {1'b0, BASE_ADDR};
    localparam logic [8:0] LAST_ADDR  = {1'b0, BASE_ADDR} + 9'(NUM_CH - 1);

    state_t            state, state_nxt;
    logic [CH_W-1:0]   act_ch;
    TCommandCode       act_cmd;
    logic [15:0]       size_lat;
    logic [CH_W-1:0]   pop_sel_q;
    logic              out_en;
    logic [NUM_CH-1:0] open_q, commit_q, rollback_q, push_to_mil_q;
    logic [RC_W-1:0]   rst_cnt;

    logic [15:0]       ms_words [NUM_CH];
    logic [15:0]       sm_words [NUM_CH];
    logic [15:0]       err_cnt  [NUM_CH];

    logic              ch_hit, start_hit, reset_accept, timeout;
    logic              abort_pkt, commit_pkt;
    logic [CH_W-1:0]   new_ch;
    logic [15:0]       new_size;

    function automatic logic [NUM_CH-1:0] onehot(input logic [CH_W-1:0] c);
        logic [NUM_CH-1:0] v;
        v    = '0;
        v[c] = 1'b1;
        return v;
    endfunction

    for (genvar c = 0; c < NUM_CH; c++) begin : g_unpack
        assign ms_words[c] = memUsedMS[16*c +: 16];
        assign sm_words[c] = memUsedSM[16*c +: 16];
    end

    // Address decode; 9-bit compare keeps the range check free of wrap-around.
    assign ch_hit    = ({1'b0, inAddr} >= FIRST_ADDR) && ({1'b0, inAddr} <= LAST_ADDR);
    assign new_ch    = CH_W'(inAddr - BASE_ADDR);
    assign new_size  = (inSize < ms_words[new_ch]) ? inSize : ms_words[new_ch];
    assign start_hit = inPacketStart && ch_hit;

    // Broadcast address only ever triggers the reset request, never the FSM.
    assign reset_accept = inPacketStart && (inCmdCode == TCC_RESET) &&
                          (ch_hit || (inAddr == BCAST_ADDR));

`ifdef MIL_SPI_PKT_TIMEOUT_EN
    logic [15:0] wd_cnt;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst)
            wd_cnt <= '0;
        else if (start_hit || (state != ST_ACTIVE))
            wd_cnt <= '0;
        else
            wd_cnt <= wd_cnt + 16'd1;
    end

    assign timeout = (state == ST_ACTIVE) && (wd_cnt == 16'(PKT_TIMEOUT - 1)) &&
                     !inPacketEnd && !inPacketErr && !start_hit;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^PKT_TIMEOUT;
    assign timeout            = 1'b0;
`endif

    // A start on top of an open packet aborts the old one exactly like Err.
    assign abort_pkt  = (state == ST_ACTIVE) && (start_hit || inPacketErr || timeout);
    assign commit_pkt = (state == ST_ACTIVE) && inPacketEnd && !inPacketErr && !start_hit;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt         = state;
        enablePushFromSpi = '0;
        popSrcStatus      = 1'b0;
        statusEnable      = 1'b0;
        outDataSize       = '0;
        outCmdCode        = TCC_UNKNOWN;
        case (state)
            ST_IDLE: begin
                if (start_hit)
                    state_nxt = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                outCmdCode = act_cmd;
                case (act_cmd)
                    TCC_SEND_DATA:    enablePushFromSpi = onehot(act_ch);
                    TCC_RECEIVE_STS: begin
                        popSrcStatus = 1'b1;
                        statusEnable = 1'b1;
                        outDataSize  = 16'd3;
                    end
                    TCC_RECEIVE_DATA: outDataSize = size_lat;
                    default:          ;
                endcase
                if (start_hit)
                    state_nxt = ST_ACTIVE;
                else if (abort_pkt || commit_pkt)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            act_ch        <= '0;
            act_cmd       <= TCC_UNKNOWN;
            size_lat      <= '0;
            pop_sel_q     <= '0;
            out_en        <= 1'b0;
            open_q        <= '0;
            commit_q      <= '0;
            rollback_q    <= '0;
            push_to_mil_q <= '0;
        end else begin
            out_en     <= 1'b1;
            open_q     <= '0;
            commit_q   <= '0;
            rollback_q <= '0;
            if (abort_pkt && (act_cmd == TCC_SEND_DATA))
                rollback_q <= onehot(act_ch);
            if (commit_pkt && (act_cmd == TCC_SEND_DATA))
                commit_q <= onehot(act_ch);
            if (start_hit) begin
                act_ch   <= new_ch;
                act_cmd  <= inCmdCode;
                size_lat <= new_size;
                if (inCmdCode == TCC_SEND_DATA)
                    open_q <= onehot(new_ch);
                // popSel only moves on a data read so status words keep tracking it.
                if (inCmdCode == TCC_RECEIVE_DATA)
                    pop_sel_q <= new_ch;
            end
            for (int c = 0; c < NUM_CH; c++)
                push_to_mil_q[c] <= (sm_words[c] != 16'h0);
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            for (int c = 0; c < NUM_CH; c++)
                err_cnt[c] <= '0;
        end else if (abort_pkt && (err_cnt[act_ch] != 16'hFFFF)) begin
            err_cnt[act_ch] <= err_cnt[act_ch] + 16'd1;
        end
    end

    // Request is low while the counter is non-zero: RST_HOLD cycles per reload.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst)
            rst_cnt <= '0;
        else if (reset_accept)
            rst_cnt <= RC_W'(RST_HOLD);
        else if (rst_cnt != '0)
            rst_cnt <= rst_cnt - RC_W'(1);
    end

    assign outAddr         = BASE_ADDR + 8'(act_ch);
    assign outEnable       = out_en;
    assign smOpen          = open_q;
    assign smCommit        = commit_q;
    assign smRollback      = rollback_q;
    assign enablePushToMil = push_to_mil_q;
    assign popSel          = pop_sel_q;
    assign statusWord0     = ms_words[pop_sel_q];
    assign statusWord1     = sm_words[pop_sel_q];
    assign statusWord2     = err_cnt[pop_sel_q];
    assign nResetRequest   = (rst_cnt == '0);

endmodule

`default_nettype wire
